mapper_bank_ctrl: RTL and testbench

Synchronous register controller for the SSF-style cartridge mapper. It samples the asynchronous Mega Drive write strobes in the CPLD clock domain and decodes writes to $A130F1–$A130FF. It holds the seven 6-bit bank registers and the two SRAM control bits that drive the mapper's ROM address and chip-select datapath. It replaces capture on the raw `lwr` edge with a filtered, glitch-rejecting capture FSM.

---
 rtl/mapper_bank_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mapper_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_bank_ctrl.sv
// mapper_bank_ctrl: SSF mapper bank/SRAM register file with synchronised, glitch-filtered write capture.
// Define MAPPER_READBACK_EN to build the register readback path (rd_oe/rd_data); otherwise both are tied to 0.
module mapper_bank_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        vres,
  input  logic        tme,
  input  logic        lwr,
  input  logic        cas0,
  input  logic        ce_0,
  input  logic [8:1]  cart_address,
  input  logic [7:0]  cart_data_in,
  output logic [41:0] bank_flat,
  output logic        sram_enabled,
  output logic        sram_writable,
  output logic        reg_wr,
  output logic        busy,
  output logic        rd_oe,
  output logic [7:0]  rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [41:0] BANK_RESET  = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] tme_sync_r;
  logic [SYNC_STAGES-1:0] lwr_sync_r;
  logic [SYNC_STAGES-1:0] cas0_sync_r;
  logic [SYNC_STAGES-1:0] ce0_sync_r;
  logic [SYNC_STAGES-1:0] valid_r;
  logic                   lwr_prev_r;
  logic [3:0]             cnt_r;
  logic [41:0]            bank_r;
  logic                   sram_en_r;
  logic                   sram_wr_r;
  logic                   reg_wr_r;
  logic                   busy_r;

  logic tme_s;
  logic lwr_s;
  logic cas0_s;
  logic ce0_s;
  logic hit_s;
  logic fall_s;
  logic unused_data_s;

  assign tme_s         = tme_sync_r[SYNC_STAGES-1];
  assign lwr_s         = lwr_sync_r[SYNC_STAGES-1];
  assign cas0_s        = cas0_sync_r[SYNC_STAGES-1];
  assign ce0_s         = ce0_sync_r[SYNC_STAGES-1];
  assign hit_s         = ~tme_s & cas0_s & ce0_s & (cart_address[8:4] == 5'b01111);
  // No edge is seen until the synchroniser has refilled, so a strobe held low through reset is ignored.
  assign fall_s        = lwr_prev_r & ~lwr_s;
  assign unused_data_s = ^cart_data_in[7:6];

  assign bank_flat     = bank_r;
  assign sram_enabled  = sram_en_r;
  assign sram_writable = sram_wr_r;
  assign reg_wr        = reg_wr_r;
  assign busy          = busy_r;

  // Strobe synchronisers and falling-edge history.
  always_ff @(posedge clk) begin
    if (!vres) begin
      tme_sync_r  <= {SYNC_STAGES{1'b1}};
      lwr_sync_r  <= {SYNC_STAGES{1'b1}};
      cas0_sync_r <= {SYNC_STAGES{1'b1}};
      ce0_sync_r  <= {SYNC_STAGES{1'b1}};
      valid_r     <= {SYNC_STAGES{1'b0}};
      lwr_prev_r  <= 1'b0;
    end else begin
      tme_sync_r  <= {tme_sync_r[SYNC_STAGES-2:0], tme};
      lwr_sync_r  <= {lwr_sync_r[SYNC_STAGES-2:0], lwr};
      cas0_sync_r <= {cas0_sync_r[SYNC_STAGES-2:0], cas0};
      ce0_sync_r  <= {ce0_sync_r[SYNC_STAGES-2:0], ce_0};
      valid_r     <= {valid_r[SYNC_STAGES-2:0], 1'b1};
      lwr_prev_r  <= valid_r[SYNC_STAGES-1] ? lwr_s : 1'b0;
    end
  end

  // Capture FSM and the register file it writes.
  always_ff @(posedge clk) begin
    if (!vres) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      bank_r    <= BANK_RESET;
      sram_en_r <= 1'b0;
      sram_wr_r <= 1'b0;
      reg_wr_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      reg_wr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s && hit_s) begin
            state_r <= SETTLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SETTLE: begin
          if (lwr_s || !hit_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == SETTLE_LAST) begin
            state_r <= CAPTURE;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
          end
        end
        CAPTURE: begin
          // The strobe must still be low here, which sets the minimum accepted pulse width.
          if (lwr_s || !hit_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            if (cart_address[3:1] == 3'd0) begin
              sram_en_r <= cart_data_in[0];
              sram_wr_r <= cart_data_in[1];
            end else begin
              for (int n = 1; n < 8; n++) begin
                if (cart_address[3:1] == n[2:0]) begin
                  bank_r[6*n-6 +: 6] <= cart_data_in[5:0];
                end
              end
            end
            reg_wr_r <= 1'b1;
            state_r  <= RELEASE;
          end
        end
        RELEASE: begin
          if (lwr_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAPPER_READBACK_EN
  logic rd_oe_r;
  logic [7:0] rd_data_r;
  logic rd_hit_s;

  assign rd_hit_s = hit_s & lwr_s;
  assign rd_oe    = rd_oe_r;
  assign rd_data  = rd_data_r;

  function automatic logic [7:0] rd_value(input logic [2:0] sel, input logic [41:0] banks,
                                          input logic wr, input logic en);
    case (sel)
      3'd0:    return {6'b000000, wr, en};
      3'd1:    return {2'b00, banks[5:0]};
      3'd2:    return {2'b00, banks[11:6]};
      3'd3:    return {2'b00, banks[17:12]};
      3'd4:    return {2'b00, banks[23:18]};
      3'd5:    return {2'b00, banks[29:24]};
      3'd6:    return {2'b00, banks[35:30]};
      3'd7:    return {2'b00, banks[41:36]};
      default: return 8'h00;
    endcase
  endfunction

  // Readback drive, only while the capture FSM is idle.
  always_ff @(posedge clk) begin
    if (!vres) begin
      rd_oe_r   <= 1'b0;
      rd_data_r <= 8'h00;
    end else if ((state_r == IDLE) && rd_hit_s) begin
      rd_oe_r   <= 1'b1;
      rd_data_r <= rd_value(cart_address[3:1], bank_r, sram_wr_r, sram_en_r);
    end else begin
      rd_oe_r   <= 1'b0;
      rd_data_r <= 8'h00;
    end
  end
`else
  assign rd_oe   = 1'b0;
  assign rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_mapper_bank_ctrl.sv
// Directed self-checking bench for mapper_bank_ctrl (default parameters).
module tb_mapper_bank_ctrl;

  logic        clk = 1'b0;
  logic        vres;
  logic        tme;
  logic        lwr;
  logic        cas0;
  logic        ce_0;
  logic [8:1]  cart_address;
  logic [7:0]  cart_data_in;
  logic [41:0] bank_flat;
  logic        sram_enabled;
  logic        sram_writable;
  logic        reg_wr;
  logic        busy;
  logic        rd_oe;
  logic [7:0]  rd_data;

  localparam logic [41:0] BANK_DEF = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [41:0] bank_exp;
  logic sram_en_exp;
  logic sram_wr_exp;

  mapper_bank_ctrl dut (
    .clk(clk), .vres(vres), .tme(tme), .lwr(lwr), .cas0(cas0), .ce_0(ce_0),
    .cart_address(cart_address), .cart_data_in(cart_data_in),
    .bank_flat(bank_flat), .sram_enabled(sram_enabled), .sram_writable(sram_writable),
    .reg_wr(reg_wr), .busy(busy), .rd_oe(rd_oe), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] set_bank(input logic [41:0] b, input int n, input logic [5:0] v);
    logic [41:0] r;
    r = b;
    r[6*n-6 +: 6] = v;
    return r;
  endfunction

  // One bus write: lwr low for low_n cycles, then 6 high cycles; reg_wr pulses are counted.
  task automatic write_bus(input logic [8:1] a, input logic [7:0] d, input int low_n, input logic ce,
                           output int pulses, output int first_at, output logic [41:0] bank_at,
                           output logic saw_busy);
    @(negedge clk);
    cart_address = a; cart_data_in = d; ce_0 = ce; tme = 1'b0; lwr = 1'b0;
    pulses = 0; first_at = -1; bank_at = 42'd0; saw_busy = 1'b0;
    for (int i = 1; i <= low_n + 6; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
      if (reg_wr === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          bank_at = bank_flat;
        end
      end
      if (i == low_n) lwr = 1'b1;
    end
    tme = 1'b1; ce_0 = 1'b1;
  endtask

  task automatic check_regs(input string name);
    total_cnt++;
    if (bank_flat !== bank_exp) $display("FAIL %s bank_flat: got %h expected %h", name, bank_flat, bank_exp);
    else pass_cnt++;
    total_cnt++;
    if ({sram_writable, sram_enabled} !== {sram_wr_exp, sram_en_exp})
      $display("FAIL %s sram: got %b%b expected %b%b", name, sram_writable, sram_enabled, sram_wr_exp, sram_en_exp);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    vres = 1'b0; tme = 1'b1; lwr = 1'b1; cas0 = 1'b1; ce_0 = 1'b1;
    cart_address = 8'h00; cart_data_in = 8'h00;
    repeat (3) @(negedge clk);
    vres = 1'b1;
    repeat (4) @(negedge clk);
    bank_exp = BANK_DEF; sram_en_exp = 1'b0; sram_wr_exp = 1'b0;
    check_regs("reset");
    total_cnt++;
    if ({busy, reg_wr, rd_oe} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, reg_wr, rd_oe});
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    else pass_cnt++;
  endtask

  task automatic test_bank_write;
    int p, f; logic [41:0] b; logic sb;
    write_bus(8'h79, 8'h2A, 8, 1'b1, p, f, b, sb);
    bank_exp = set_bank(bank_exp, 1, 6'h2A);
    total_cnt++;
    if (p !== 1) $display("FAIL bank1_pulses: got %0d expected 1", p); else pass_cnt++;
    total_cnt++;
    if (f !== 6) $display("FAIL bank1_latency: got %0d expected 6", f); else pass_cnt++;
    total_cnt++;
    if (b !== bank_exp) $display("FAIL bank1_value_at_pulse: got %h expected %h", b, bank_exp); else pass_cnt++;
    check_regs("bank1");
    // Data bits [7:6] are dropped.
    write_bus(8'h7F, 8'hD5, 8, 1'b1, p, f, b, sb);
    bank_exp = set_bank(bank_exp, 7, 6'h15);
    total_cnt++;
    if (p !== 1) $display("FAIL bank7_pulses: got %0d expected 1", p); else pass_cnt++;
    check_regs("bank7");
  endtask

  task automatic test_sram_ctrl;
    int p, f; logic [41:0] b; logic sb;
    write_bus(8'h78, 8'h03, 8, 1'b1, p, f, b, sb);
    sram_en_exp = 1'b1; sram_wr_exp = 1'b1;
    check_regs("sram_03");
    write_bus(8'h78, 8'h01, 8, 1'b1, p, f, b, sb);
    sram_wr_exp = 1'b0;
    check_regs("sram_01");
    total_cnt++;
    if (p !== 1) $display("FAIL sram_pulses: got %0d expected 1", p); else pass_cnt++;
  endtask

  task automatic test_short_pulse;
    int p, f; logic [41:0] b; logic sb;
    write_bus(8'h7F, 8'h3F, 3, 1'b1, p, f, b, sb);
    total_cnt++;
    if (p !== 0) $display("FAIL short_pulses: got %0d expected 0", p); else pass_cnt++;
    total_cnt++;
    if (sb !== 1'b1) $display("FAIL short_busy_seen: got %b expected 1", sb); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL short_idle: got %b expected 0", busy); else pass_cnt++;
    check_regs("short");
  endtask

  task automatic test_ignored;
    int p, f; logic [41:0] b; logic sb;
    write_bus(8'h71, 8'h3F, 8, 1'b1, p, f, b, sb);
    total_cnt++;
    if (p !== 0) $display("FAIL bad_prefix_pulses: got %0d expected 0", p); else pass_cnt++;
    check_regs("bad_prefix");
    write_bus(8'h79, 8'h3F, 8, 1'b0, p, f, b, sb);
    total_cnt++;
    if (p !== 0) $display("FAIL ce0_low_pulses: got %0d expected 0", p); else pass_cnt++;
    check_regs("ce0_low");
  endtask

  task automatic test_back_to_back;
    int p; logic [41:0] b_first;
    logic [41:0] exp_first;
    p = 0; b_first = 42'd0;
    @(negedge clk);
    cart_address = 8'h7A; cart_data_in = 8'h11; tme = 1'b0; lwr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (reg_wr === 1'b1) begin p++; b_first = bank_flat; end
    end
    lwr = 1'b1;
    @(negedge clk);
    if (reg_wr === 1'b1) p++;
    cart_address = 8'h7B; cart_data_in = 8'h22; lwr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (reg_wr === 1'b1) p++;
    end
    lwr = 1'b1;
    repeat (6) @(negedge clk);
    tme = 1'b1;
    exp_first = set_bank(bank_exp, 2, 6'h11);
    bank_exp = set_bank(exp_first, 3, 6'h22);
    total_cnt++;
    if (p !== 2) $display("FAIL b2b_pulses: got %0d expected 2", p); else pass_cnt++;
    total_cnt++;
    if (b_first !== exp_first) $display("FAIL b2b_first: got %h expected %h", b_first, exp_first); else pass_cnt++;
    check_regs("b2b");
  endtask

  task automatic test_readback;
    logic       exp_oe;
    logic [7:0] exp_d;
    @(negedge clk);
    cart_address = 8'h7F; tme = 1'b0; lwr = 1'b1;
    repeat (4) @(negedge clk);
`ifdef MAPPER_READBACK_EN
    exp_oe = 1'b1; exp_d = 8'h15;
`else
    exp_oe = 1'b0; exp_d = 8'h00;
`endif
    total_cnt++;
    if (rd_oe !== exp_oe) $display("FAIL rb_bank7_oe: got %b expected %b", rd_oe, exp_oe); else pass_cnt++;
    total_cnt++;
    if (rd_data !== exp_d) $display("FAIL rb_bank7_data: got %h expected %h", rd_data, exp_d); else pass_cnt++;
    cart_address = 8'h78;
    repeat (2) @(negedge clk);
`ifdef MAPPER_READBACK_EN
    exp_d = {6'b000000, sram_wr_exp, sram_en_exp};
`else
    exp_d = 8'h00;
`endif
    total_cnt++;
    if (rd_data !== exp_d) $display("FAIL rb_sram_data: got %h expected %h", rd_data, exp_d); else pass_cnt++;
    tme = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (rd_oe !== 1'b0) $display("FAIL rb_release_oe: got %b expected 0", rd_oe); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write;
    int p;
    p = 0;
    @(negedge clk);
    cart_address = 8'h79; cart_data_in = 8'h3F; tme = 1'b0; lwr = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else pass_cnt++;
    vres = 1'b0;
    repeat (2) @(negedge clk);
    vres = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (reg_wr === 1'b1) p++;
    end
    bank_exp = BANK_DEF; sram_en_exp = 1'b0; sram_wr_exp = 1'b0;
    total_cnt++;
    if (p !== 0) $display("FAIL midrst_pulses: got %0d expected 0", p); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
    check_regs("midrst_held");
    lwr = 1'b1; tme = 1'b1;
    repeat (4) @(negedge clk);
    check_regs("midrst_after");
  endtask

  initial begin
    test_reset();
    test_bank_write();
    test_sram_ctrl();
    test_short_pulse();
    test_ignored();
    test_back_to_back();
    test_readback();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
